// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int REG_W_DEF = 5;
  localparam int CNT_W_DEF = 32;

  // Accelerator handshake phases
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } acc_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of pipeline status inputs, accelerator handshake and stage controls.
interface pipe_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [REG_W-1:0] ex_rd;
  logic             ex_mem_read;
  logic             ex_redirect;
  logic             ex_acc_op;
  logic             mem_wait;
  logic             acc_ready;
  logic             acc_done;
  logic             acc_start;
  logic             pc_stall;
  logic             stall_d;
  logic             bubble_d;
  logic             stall_e;
  logic             bubble_e;
  logic             stall_m;
  logic             bubble_m;
  logic             stall_w;
  logic             bubble_w;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Pipeline / environment side
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_redirect, ex_acc_op, mem_wait, acc_ready, acc_done,
    input  acc_start, pc_stall, stall_d, bubble_d, stall_e, bubble_e,
           stall_m, bubble_m, stall_w, bubble_w, stall_cnt, flush_cnt
  );

  // Controller side
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_redirect, ex_acc_op, mem_wait, acc_ready, acc_done,
    output acc_start, pc_stall, stall_d, bubble_d, stall_e, bubble_e,
           stall_m, bubble_m, stall_w, bubble_w, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_acc_handshake_fsm.sv
// Accelerator request/completion handshake.
// state | meaning
// IDLE  | no accelerator op outstanding; requests as soon as one reaches EX
// REQ   | acc_start held, waiting for acc_ready
// WAIT  | accepted, waiting for the acc_done pulse
// DONE  | acc_done seen during a memory wait; releases when mem_wait drops
module acc_handshake_fsm
  import pipe_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ex_acc_op,
  input  logic acc_ready,
  input  logic acc_done,
  input  logic mem_wait,
  output logic acc_start,
  output logic acc_busy,
  output logic acc_release
);

  acc_state_t state, state_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake flags
  always_comb begin
    state_nxt   = state;
    acc_start   = 1'b0;
    acc_busy    = 1'b0;
    acc_release = 1'b0;
    case (state)
      IDLE: begin
        acc_start = ex_acc_op;
        acc_busy  = ex_acc_op;
        if (ex_acc_op) state_nxt = acc_ready ? WAIT : REQ;
      end
      REQ: begin
        acc_start = 1'b1;
        acc_busy  = 1'b1;
        if (acc_ready) state_nxt = WAIT;
      end
      WAIT: begin
        acc_busy = 1'b1;
        if (acc_done) begin
          acc_release = ~mem_wait;
          state_nxt   = mem_wait ? DONE : IDLE;
        end
      end
      DONE: begin
        if (!mem_wait) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: priority resolver, load-use detect, perf counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic             clk,
  input logic             rst,
  pipe_hazard_ctrl_if.slave bus
);

  logic acc_start_raw;
  logic acc_busy;
  logic acc_release;
  logic load_use;
  logic flush_apply;
  logic pc_stall_c;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  acc_handshake_fsm u_acc_fsm (
    .clk         (clk),
    .rst         (rst),
    .ex_acc_op   (bus.ex_acc_op),
    .acc_ready   (bus.acc_ready),
    .acc_done    (bus.acc_done),
    .mem_wait    (bus.mem_wait),
    .acc_start   (acc_start_raw),
    .acc_busy    (acc_busy),
    .acc_release (acc_release)
  );

  // Load-use: a load in EX writing a register the ID instruction reads (x0 never hazards)
  always_comb begin
    load_use = bus.ex_mem_read && (bus.ex_rd != REG_W'(0)) &&
               ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));
  end

  // Priority resolver; a blocked redirect stays in EX and is applied once unblocked
  always_comb begin
    pc_stall_c   = 1'b0;
    bus.stall_d  = 1'b0;
    bus.bubble_d = 1'b0;
    bus.stall_e  = 1'b0;
    bus.bubble_e = 1'b0;
    bus.stall_m  = 1'b0;
    bus.bubble_m = 1'b0;
    bus.stall_w  = 1'b0;
    bus.bubble_w = 1'b0;
    flush_apply  = 1'b0;
    if (rst) begin
      bus.bubble_d = 1'b1;
      bus.bubble_e = 1'b1;
      bus.bubble_m = 1'b1;
      bus.bubble_w = 1'b1;
    end else if (bus.mem_wait) begin
      pc_stall_c   = 1'b1;
      bus.stall_d  = 1'b1;
      bus.stall_e  = 1'b1;
      bus.stall_m  = 1'b1;
      bus.bubble_w = 1'b1;
    end else if (acc_busy && !acc_release) begin
      pc_stall_c   = 1'b1;
      bus.stall_d  = 1'b1;
      bus.stall_e  = 1'b1;
      bus.bubble_m = 1'b1;
    end else if (bus.ex_redirect) begin
      bus.bubble_d = 1'b1;
      bus.bubble_e = 1'b1;
      flush_apply  = 1'b1;
    end else if (load_use) begin
      pc_stall_c   = 1'b1;
      bus.stall_d  = 1'b1;
      bus.bubble_e = 1'b1;
    end
  end

  // Free-running performance counters, wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(pc_stall_c);
      flush_cnt_q <= flush_cnt_q + CNT_W'(flush_apply);
    end
  end

  assign bus.pc_stall  = pc_stall_c;
  assign bus.acc_start = acc_start_raw & ~rst;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline controller for the five-stage RISC-V core with attached accelerator. It drives the `stall`/`bubble` pair of every inter-stage pipe register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC hold. It resolves load-use hazards, EX-stage branch redirects, data-memory wait and the multi-cycle accelerator handshake. It also keeps two free-running performance counters.

## Interface
- `REG_W`, 5, register-index width
- `CNT_W`, 32, performance-counter width

- `clk` in 1: core clock
- `rst` in 1: synchronous, active-high reset
- `id_rs1`, `id_rs2` in REG_W: source registers of the instruction in ID
- `id_use_rs1`, `id_use_rs2` in 1: the ID instruction actually reads rs1 / rs2
- `ex_rd` in REG_W: destination register of the instruction in EX
- `ex_mem_read` in 1: the EX instruction is a load
- `ex_redirect` in 1: a taken branch or jump resolved in EX
- `ex_acc_op` in 1: the EX instruction is an accelerator op
- `mem_wait` in 1: data memory not ready, so the MEM access cannot complete
- `acc_ready` in 1: accelerator accepts `acc_start`
- `acc_done` in 1: one-cycle completion pulse from the accelerator
- `acc_start` out 1: accelerator request, held until accepted
- `pc_stall` out 1: PC hold
- `stall_d`, `bubble_d` out 1: IF/ID register control
- `stall_e`, `bubble_e` out 1: ID/EX register control
- `stall_m`, `bubble_m` out 1: EX/MEM register control
- `stall_w`, `bubble_w` out 1: MEM/WB register control
- `stall_cnt` out CNT_W: cycles with `pc_stall`=1
- `flush_cnt` out CNT_W: redirects applied

## Operation
- All stall/bubble outputs are combinational from the FSM state plus the current inputs, so the response has zero latency. Counters and the FSM are registered.
- Resolve hazards in strict priority order. Stages not named in a rule keep stall=0 and bubble=0.
  1. Memory wait (`mem_wait`=1, or FSM in DONE with `mem_wait`=1): assert `pc_stall`, `stall_d`, `stall_e` and `stall_m`; assert `bubble_w`.
  2. Accelerator busy (FSM in REQ or WAIT, or in IDLE with `ex_acc_op`=1): assert `pc_stall`, `stall_d` and `stall_e`; assert `bubble_m`. One exception: in the WAIT cycle where `acc_done`=1 and `mem_wait`=0, release everything so the op advances to MEM.
  3. Redirect (`ex_redirect`=1): assert `bubble_d` and `bubble_e`. Do not assert `pc_stall`. Increment `flush_cnt`.
  4. Load-use: the hazard exists when `ex_mem_read`=1 and `ex_rd`≠0, and either (`id_use_rs1` and `id_rs1`==`ex_rd`) or (`id_use_rs2` and `id_rs2`==`ex_rd`). Assert `pc_stall` and `stall_d`; assert `bubble_e`.
- A redirect blocked by rules 1–2 is not lost. It stays in the stalled EX stage and is applied in the first unblocked cycle, where it counts once.
- Accelerator FSM transitions:
  - IDLE: `acc_start`=`ex_acc_op`. Go to WAIT if `ex_acc_op` and `acc_ready`; go to REQ if `ex_acc_op` and not `acc_ready`.
  - REQ: `acc_start`=1. Go to WAIT when `acc_ready`.
  - WAIT: `acc_start`=0. Go to IDLE when `acc_done` and not `mem_wait`; go to DONE when `acc_done` and `mem_wait`. `acc_done` is ignored in IDLE and REQ.
  - DONE: `acc_done` was latched during a memory wait. Go to IDLE when `mem_wait`=0; the pipeline releases in that cycle.
- `stall_cnt` increments when `pc_stall`=1, and `flush_cnt` increments per applied redirect. Both wrap modulo 2^CNT_W.

## Timing
- Reset:
  - FSM goes to IDLE; both counters go to 0.
  - While `rst`=1: `acc_start`=0, `pc_stall`=0, all `stall_*`=0 and all `bubble_*`=1.
  - Reset in REQ, WAIT or DONE abandons the accelerator op. There is no handshake on abort.
- Accelerator op entering EX in cycle N with `acc_ready`=1:
  - `acc_start`=1 in cycle N.
  - WAIT from N+1.
  - With `acc_done` at cycle K and no memory wait, the op moves to MEM at K+1.
  - `pc_stall` is asserted in cycles N..K−1, i.e. K−N cycles.
- `acc_done` in the same cycle as `acc_start` is not legal and is ignored.
- Load-use costs exactly one bubble. Redirect costs two flushed instructions.

## Structure
- Package `pipe_ctrl_pkg`: the FSM state enum {IDLE, REQ, WAIT, DONE}, plus the `REG_W` and `CNT_W` defaults.
- Sub-module `acc_handshake_fsm`: owns the state register, `acc_start`, and the busy/release/DONE flags.
- The top level holds the priority resolver, the load-use comparator and the counters.

## Test plan
- Load-use: `ex_mem_read`=1, `ex_rd`=5, `id_rs2`=5, `id_use_rs2`=1 → one cycle of `pc_stall`=`stall_d`=`bubble_e`=1, and `stall_cnt` becomes 1. Repeat with `ex_rd`=0 → no stall.
- Redirect: `ex_redirect`=1 for one cycle → `bubble_d`=`bubble_e`=1 and `pc_stall`=0, and `flush_cnt` becomes 1.
- Accelerator: `ex_acc_op` at cycle 10, `acc_ready` low until cycle 12, `acc_done` at cycle 20 → `acc_start`=1 in cycles 10–12, stalls in cycles 10–19, release at cycle 20, `stall_cnt`=10.
- Done during memory wait: `acc_done` at cycle 20 while `mem_wait`=1 until cycle 23 → DONE in cycles 21–23, `stall_m`=1 and `bubble_w`=1 meanwhile, release at cycle 23.
- Priority: `mem_wait`=1 together with `ex_redirect`=1 for 3 cycles → no flush during those cycles; the flush is applied once in the cycle `mem_wait` drops, and `flush_cnt`=1.
- Reset in WAIT: `rst` pulsed → FSM goes to IDLE, counters go to 0, a later `acc_done` is ignored, and all bubbles=1 during reset.
